uart_rx_stream: RTL
===================

Name: uart_rx_stream

Overview:
- Parametrised UART receiver: serial `rxd` → valid/ready byte stream (StreamBus Master-side semantics: data/valid/ready).
- Successor to the fixed 8N1 receiver. Adds:
  - configurable data width, stop bits and bit period;
  - 3-sample majority vote;
  - false-start rejection;
  - framing and overrun detection;
  - optional parity.
- Sits between the board RX pin and the consumer stream (FIFO, command parser).

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal ≥ 4.
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even; honoured only with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- rxd  in  1  asynchronous serial line, idle high
- m_data  out  DATA_BITS  received payload, LSB = first bit received
- m_valid  out  1  m_data holds an unconsumed word
- m_ready  in  1  consumer accepts; transfer when m_valid & m_ready on a clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without macro
- overrun  out  1  one-cycle pulse: new word lost because holding register full

Behaviour:
- Reset (rst low at clk edge) sets:
  - m_valid = 0, m_data = 0, all error pulses 0;
  - state WAIT, counters 0;
  - 2-FF synchroniser = 1;
  - armed = 0.
- Reset mid-frame abandons the frame with no output and no error.
- Input path:
  - 2-FF synchroniser, then 3-bit history shift register.
  - Bit value = majority of the last 3 synchronised samples, evaluated at the sample point.
- armed is set once the synchronised line is seen high after reset. WAIT ignores falling edges until armed, so a line held low across reset is never taken as a start bit.
- Bit counter width is $clog2(CLKS_PER_BIT). Sample point is count == CLKS_PER_BIT/2 (integer division), measured from the start-edge cycle.
- FSM states: WAIT, START, DATA, PARITY, STOP.
  - WAIT: on armed and a synchronised 1→0 transition, go to START with the counter cleared.
  - START: at the sample point, majority 0 → DATA (counter restarts, bit index 0); majority 1 → WAIT. The latter is a false start: no output, no error.
  - DATA: sample every CLKS_PER_BIT cycles and shift in LSB-first. After bit DATA_BITS-1, go to PARITY if parity is enabled and PARITY != 0, otherwise STOP.
  - PARITY: sample one bit and compare with XOR(payload) (even) or ~XOR(payload) (odd). Always continue to STOP; the mismatch is remembered.
  - STOP: sample STOP_BITS bits. After the mid-point of the last stop bit:
    - any stop sample 0 → frame_err pulse, word dropped, go to WAIT, armed cleared;
    - else parity mismatch → parity_err pulse, word dropped, go to WAIT;
    - else word complete, go to WAIT.
    - Frame_err takes priority over parity_err. Only one error pulses per frame.
  - Returning to WAIT at mid-stop gives half a bit of resync margin.
- Output register:
  - A complete word loads m_data and sets m_valid on the cycle after the final stop sample point.
  - Full register (m_valid=1) not consumed that cycle → overrun pulse; old m_data is kept and the new word is discarded.
  - m_valid & m_ready on the same cycle as a completing word → new word loaded, m_valid stays 1, no overrun.
  - m_valid & m_ready with no new word → m_valid = 0 next cycle; m_data holds its value.
- Error pulses are exactly one clk cycle wide and never coincide with a load into the output register.
- Any rxd change while not in WAIT has no effect except at sample points.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state and checker are compiled in;
  - PARITY parameter selects none/odd/even;
  - parity_err is driven as above.
- Undefined:
  - no PARITY state, no checker logic;
  - PARITY parameter is ignored; frames are always data + stop;
  - parity_err is tied to 0.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated):
- Send 0xA5 8N1, m_ready=1 → m_valid high one cycle with m_data=0xA5; all error outputs 0.
- Send 0x00 then 0xFF back-to-back, m_ready=0 → m_data=0x00 held; overrun pulses once at the 0xFF stop; then raise m_ready → m_valid drops next cycle.
- Send 0x55 with stop bit driven low → frame_err pulse, m_valid stays 0. Then idle 2 bits and send 0x3C → m_data=0x3C, no error.
- Idle line, 3-cycle low glitch → START rejects at sample point; no m_valid, no errors. A 1-cycle glitch inside a data bit at its sample point → majority filters it, byte correct.
- With UART_RX_PARITY_EN, PARITY=2: send 0x07 with parity bit 1 → accepted; resend with parity bit 0 → parity_err pulse, no m_valid.
- Assert rst during bit 3 of 0x81 while rxd low, release with rxd still low → no output. After rxd high for ≥1 bit, send 0x81 → m_data=0x81.

Source files
------------

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: parametrised UART receiver (majority-voted samples, framing/overrun checks) to a data/valid/ready stream.
// Define UART_RX_PARITY_EN to compile in the parity state and checker; otherwise parity_err is tied low.
module uart_rx_stream #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int unsigned   CW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IW    = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] SLAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t               state;
    logic                 sync1, sync2;
    logic [2:0]           hist;
    logic                 armed;
    logic                 maj;
    logic                 stop_bad;
    logic                 done;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 par_exp;

    always_comb par_exp = (PARITY == 2) ? ^shreg : ~^shreg;
`else
    assign parity_err = 1'b0;
`endif

    always_comb maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    // hist resets to zero so the synchroniser's reset ones can never fill it and arm a line held low
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            hist       <= '0;
            armed      <= 1'b0;
            state      <= ST_WAIT;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            stop_bad   <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            hist      <= {hist[1:0], sync2};
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (hist == 3'b111)
                armed <= 1'b1;
            case (state)
                ST_WAIT: begin
                    cnt <= '0;
                    if (armed && hist[1] && !hist[0])
                        state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= maj ? ST_WAIT : ST_DATA;
                    end else
                        cnt <= cnt + 1'b1;
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                        if (idx == DLAST) begin
                            idx      <= '0;
                            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_bad  <= 1'b0;
                            if (PARITY != 0)
                                state <= ST_PARITY;
                            else
                                state <= ST_STOP;
`else
                            state    <= ST_STOP;
`endif
                        end else
                            idx <= idx + 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bad <= (maj != par_exp);
                        state   <= ST_STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
`endif
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (idx == SLAST) begin
                            idx   <= '0;
                            state <= ST_WAIT;
                            if (stop_bad || !maj) begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (par_bad)
                                parity_err <= 1'b1;
`endif
                            else
                                done <= 1'b1;
                        end else begin
                            stop_bad <= stop_bad | ~maj;
                            idx      <= idx + 1'b1;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    // shreg is stable for over a bit after done, so it feeds the holding register directly
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!m_valid || m_ready) begin
                    m_data  <= shreg;
                    m_valid <= 1'b1;
                end else
                    overrun <= 1'b1;
            end else if (m_ready)
                m_valid <= 1'b0;
        end
    end
endmodule
